// File: rtl/reservation_station.sv
// Reservation station that holds dispatched ops until their operands are committed, then issues the lowest ready entry to the ALU.
// Dispatch is accepted only while the station is not full; the stall output mirrors fullness.
module reservation_station #(
    parameter int EntryCount    = 8,
    parameter int PointerLength = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_exception_from_rob,
    input  logic        is_empty_from_rob,
    input  logic        is_sl_from_rob,
    input  logic [5:0]  op_from_rob,
    input  logic [31:0] v1_from_rob,
    input  logic [31:0] v2_from_rob,
    input  logic [31:0] q1_from_rob,
    input  logic [31:0] q2_from_rob,
    input  logic [31:0] imm_from_rob,
    input  logic [31:0] pc_from_rob,
    input  logic        is_commit_from_rob,
    input  logic [31:0] commit_pc_from_rob,
    input  logic [31:0] commit_data_from_rob,
    output logic        is_stall_to_rob,
    output logic        is_valid_to_alu,
    output logic [5:0]  op_to_alu,
    output logic [31:0] v1_to_alu,
    output logic [31:0] v2_to_alu,
    output logic [31:0] imm_to_alu,
    output logic [31:0] pc_to_alu
);
    localparam int IdxW = PointerLength + 1;
    localparam logic [31:0] NoDep = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        busy;
        logic [5:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] q1;
        logic [31:0] q2;
        logic [31:0] imm;
        logic [31:0] pc;
    } entry_t;

    entry_t ent [EntryCount];

    logic [EntryCount-1:0] busy_vec;
    logic [EntryCount-1:0] ready_vec;
    logic                  free_found;
    logic                  ready_found;
    logic [IdxW-1:0]       free_idx;
    logic [IdxW-1:0]       ready_idx;
    logic                  accept;
    logic                  byp1;
    logic                  byp2;

    // Readiness uses registered tags only, so an entry written this edge cannot issue before the next one.
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < EntryCount; i++) begin
            busy_vec[i]  = ent[i].busy;
            ready_vec[i] = ent[i].busy && (ent[i].q1 == NoDep) && (ent[i].q2 == NoDep);
        end
    end

    // Downward scans leave the lowest matching index in place.
    always_comb begin
        free_found  = 1'b0;
        ready_found = 1'b0;
        free_idx    = '0;
        ready_idx   = '0;
        for (int i = EntryCount - 1; i >= 0; i--) begin
            if (!busy_vec[i]) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
            if (ready_vec[i]) begin
                ready_found = 1'b1;
                ready_idx   = IdxW'(i);
            end
        end
    end

    assign is_stall_to_rob = &busy_vec;
    assign accept = !is_empty_from_rob && !is_sl_from_rob && !is_exception_from_rob && free_found;
    assign byp1   = is_commit_from_rob && (q1_from_rob != NoDep) && (q1_from_rob == commit_pc_from_rob);
    assign byp2   = is_commit_from_rob && (q2_from_rob != NoDep) && (q2_from_rob == commit_pc_from_rob);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < EntryCount; i++) begin
                ent[i] <= '{busy: 1'b0, op: '0, v1: '0, v2: '0, q1: NoDep, q2: NoDep, imm: '0, pc: '0};
            end
            is_valid_to_alu <= 1'b0;
            op_to_alu       <= '0;
            v1_to_alu       <= '0;
            v2_to_alu       <= '0;
            imm_to_alu      <= '0;
            pc_to_alu       <= '0;
        end else if (is_exception_from_rob) begin
            for (int i = 0; i < EntryCount; i++) begin
                ent[i].busy <= 1'b0;
            end
            is_valid_to_alu <= 1'b0;
        end else begin
            for (int i = 0; i < EntryCount; i++) begin
                if (ent[i].busy && is_commit_from_rob) begin
                    if (ent[i].q1 != NoDep && ent[i].q1 == commit_pc_from_rob) begin
                        ent[i].v1 <= commit_data_from_rob;
                        ent[i].q1 <= NoDep;
                    end
                    if (ent[i].q2 != NoDep && ent[i].q2 == commit_pc_from_rob) begin
                        ent[i].v2 <= commit_data_from_rob;
                        ent[i].q2 <= NoDep;
                    end
                end
            end
            if (ready_found) begin
                is_valid_to_alu      <= 1'b1;
                op_to_alu            <= ent[ready_idx].op;
                v1_to_alu            <= ent[ready_idx].v1;
                v2_to_alu            <= ent[ready_idx].v2;
                imm_to_alu           <= ent[ready_idx].imm;
                pc_to_alu            <= ent[ready_idx].pc;
                ent[ready_idx].busy  <= 1'b0;
            end else begin
                is_valid_to_alu <= 1'b0;
            end
            // The allocated slot was free, so it never collides with the issued or woken entries.
            if (accept) begin
                ent[free_idx] <= '{busy: 1'b1, op: op_from_rob,
                                   v1: byp1 ? commit_data_from_rob : v1_from_rob,
                                   v2: byp2 ? commit_data_from_rob : v2_from_rob,
                                   q1: byp1 ? NoDep : q1_from_rob,
                                   q2: byp2 ? NoDep : q2_from_rob,
                                   imm: imm_from_rob, pc: pc_from_rob};
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: dispatch, wake-up, bypass, full/stall, flush, load/store filter and reset.
module tb_reservation_station;
    logic        clk = 1'b0;
    logic        rst;
    logic        is_exception_from_rob;
    logic        is_empty_from_rob;
    logic        is_sl_from_rob;
    logic [5:0]  op_from_rob;
    logic [31:0] v1_from_rob, v2_from_rob, q1_from_rob, q2_from_rob;
    logic [31:0] imm_from_rob, pc_from_rob;
    logic        is_commit_from_rob;
    logic [31:0] commit_pc_from_rob, commit_data_from_rob;
    logic        is_stall_to_rob, is_valid_to_alu;
    logic [5:0]  op_to_alu;
    logic [31:0] v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ND = 32'hFFFF_FFFF;

    reservation_station dut (
        .clk(clk), .rst(rst),
        .is_exception_from_rob(is_exception_from_rob),
        .is_empty_from_rob(is_empty_from_rob),
        .is_sl_from_rob(is_sl_from_rob),
        .op_from_rob(op_from_rob),
        .v1_from_rob(v1_from_rob), .v2_from_rob(v2_from_rob),
        .q1_from_rob(q1_from_rob), .q2_from_rob(q2_from_rob),
        .imm_from_rob(imm_from_rob), .pc_from_rob(pc_from_rob),
        .is_commit_from_rob(is_commit_from_rob),
        .commit_pc_from_rob(commit_pc_from_rob),
        .commit_data_from_rob(commit_data_from_rob),
        .is_stall_to_rob(is_stall_to_rob),
        .is_valid_to_alu(is_valid_to_alu),
        .op_to_alu(op_to_alu),
        .v1_to_alu(v1_to_alu), .v2_to_alu(v2_to_alu),
        .imm_to_alu(imm_to_alu), .pc_to_alu(pc_to_alu)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; sampling and driving happen 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        is_exception_from_rob = 1'b0;
        is_empty_from_rob     = 1'b1;
        is_sl_from_rob        = 1'b0;
        op_from_rob           = '0;
        v1_from_rob           = '0;
        v2_from_rob           = '0;
        q1_from_rob           = ND;
        q2_from_rob           = ND;
        imm_from_rob          = '0;
        pc_from_rob           = '0;
        is_commit_from_rob    = 1'b0;
        commit_pc_from_rob    = '0;
        commit_data_from_rob  = '0;
    endtask

    task automatic dispatch(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [31:0] q1, input logic [31:0] q2,
                            input logic [31:0] imm);
        is_empty_from_rob = 1'b0;
        op_from_rob  = op;
        pc_from_rob  = pc;
        v1_from_rob  = v1;
        v2_from_rob  = v2;
        q1_from_rob  = q1;
        q2_from_rob  = q2;
        imm_from_rob = imm;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] data);
        is_commit_from_rob   = 1'b1;
        commit_pc_from_rob   = pc;
        commit_data_from_rob = data;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        step();
        step();
        check("rst_valid", 32'(is_valid_to_alu), 32'd0);
        check("rst_stall", 32'(is_stall_to_rob), 32'd0);
        check("rst_pc", pc_to_alu, 32'd0);
        check("rst_v1", v1_to_alu, 32'd0);
        rst = 1'b1;

        // Ready op issues on the edge after it is accepted.
        dispatch(6'd1, 32'h10, 32'd3, 32'd4, ND, ND, 32'd9);
        step();
        idle();
        check("add_not_yet", 32'(is_valid_to_alu), 32'd0);
        step();
        check("add_valid", 32'(is_valid_to_alu), 32'd1);
        check("add_pc", pc_to_alu, 32'h10);
        check("add_v1", v1_to_alu, 32'd3);
        check("add_v2", v2_to_alu, 32'd4);
        check("add_imm", imm_to_alu, 32'd9);
        check("add_op", 32'(op_to_alu), 32'd1);
        step();
        check("add_once", 32'(is_valid_to_alu), 32'd0);
        check("add_hold_pc", pc_to_alu, 32'h10);

        // Blocked on q1 until producer 0x10 commits; a different 32-bit tag does not wake it.
        dispatch(6'd2, 32'h14, 32'd0, 32'd2, 32'h10, ND, 32'd0);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            check("dep_hold", 32'(is_valid_to_alu), 32'd0);
        end
        commit(32'h8000_0010, 32'h99);
        step();
        idle();
        step();
        check("dep_wrong_tag", 32'(is_valid_to_alu), 32'd0);
        commit(32'h10, 32'h55);
        step();
        idle();
        check("dep_wake_edge", 32'(is_valid_to_alu), 32'd0);
        step();
        check("dep_valid", 32'(is_valid_to_alu), 32'd1);
        check("dep_pc", pc_to_alu, 32'h14);
        check("dep_v1", v1_to_alu, 32'h55);
        check("dep_v2", v2_to_alu, 32'd2);

        // Commit matching an incoming q2 is captured at dispatch.
        dispatch(6'd3, 32'h18, 32'd1, 32'd0, ND, 32'h20, 32'd0);
        commit(32'h20, 32'd7);
        step();
        idle();
        step();
        check("byp_valid", 32'(is_valid_to_alu), 32'd1);
        check("byp_pc", pc_to_alu, 32'h18);
        check("byp_v2", v2_to_alu, 32'd7);
        check("byp_v1", v1_to_alu, 32'd1);

        // Fill all eight entries with distinct blocking tags.
        for (int i = 0; i < 8; i++) begin
            dispatch(6'd4, 32'h100 + 32'(4 * i), 32'(i), 32'd0, 32'h200 + 32'(i), ND, 32'd0);
            step();
            if (i == 6) check("stall_at7", 32'(is_stall_to_rob), 32'd0);
        end
        check("stall_full", 32'(is_stall_to_rob), 32'd1);
        dispatch(6'd5, 32'h1FC, 32'd1, 32'd1, ND, ND, 32'd0);
        step();
        idle();
        step();
        check("drop_no_issue", 32'(is_valid_to_alu), 32'd0);
        check("drop_stall", 32'(is_stall_to_rob), 32'd1);
        commit(32'h200, 32'hAB);
        step();
        idle();
        check("free_wake_stall", 32'(is_stall_to_rob), 32'd1);
        step();
        check("free_valid", 32'(is_valid_to_alu), 32'd1);
        check("free_pc", pc_to_alu, 32'h100);
        check("free_v1", v1_to_alu, 32'hAB);
        check("free_stall", 32'(is_stall_to_rob), 32'd0);
        dispatch(6'd6, 32'h300, 32'd5, 32'd6, ND, ND, 32'd0);
        step();
        idle();
        check("reuse_stall", 32'(is_stall_to_rob), 32'd1);
        step();
        check("reuse_pc", pc_to_alu, 32'h300);
        check("reuse_valid", 32'(is_valid_to_alu), 32'd1);

        // Flush with a ready entry pending: nothing issues, station empties.
        dispatch(6'd7, 32'h400, 32'd1, 32'd2, ND, ND, 32'd0);
        step();
        idle();
        check("pre_flush_stall", 32'(is_stall_to_rob), 32'd1);
        is_exception_from_rob = 1'b1;
        step();
        idle();
        check("flush_valid", 32'(is_valid_to_alu), 32'd0);
        check("flush_stall", 32'(is_stall_to_rob), 32'd0);
        commit(32'h201, 32'h1);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_flush_idle", 32'(is_valid_to_alu), 32'd0);
        end

        // Load/store dispatch is ignored.
        dispatch(6'd8, 32'h500, 32'd1, 32'd1, ND, ND, 32'd0);
        is_sl_from_rob = 1'b1;
        step();
        idle();
        step();
        check("sl_no_issue", 32'(is_valid_to_alu), 32'd0);
        check("sl_stall", 32'(is_stall_to_rob), 32'd0);

        // Reset mid-traffic wins over a ready entry.
        dispatch(6'd9, 32'h600, 32'd8, 32'd9, ND, ND, 32'd1);
        step();
        idle();
        rst = 1'b0;
        step();
        check("mid_rst_valid", 32'(is_valid_to_alu), 32'd0);
        check("mid_rst_pc", pc_to_alu, 32'd0);
        check("mid_rst_v1", v1_to_alu, 32'd0);
        check("mid_rst_op", 32'(op_to_alu), 32'd0);
        check("mid_rst_imm", imm_to_alu, 32'd0);
        rst = 1'b1;
        step();
        check("after_rst_idle", 32'(is_valid_to_alu), 32'd0);
        check("after_rst_stall", 32'(is_stall_to_rob), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
